// File: rtl/gardner_pkg.sv
// Shared types and derived constants for the Gardner symbol-timing NCO.
package gardner_pkg;

  typedef enum logic [1:0] {IDLE, FIRST_HALF, SECOND_HALF} state_e;

  function automatic int step_f(int frac);
    return 1 << frac;
  endfunction

  function automatic int p0_f(int osr_log2, int frac);
    return 1 << (osr_log2 + frac);
  endfunction

  function automatic int pmin_f(int osr_log2, int frac);
    return p0_f(osr_log2, frac) - p0_f(osr_log2, frac) / 4;
  endfunction

  function automatic int pmax_f(int osr_log2, int frac);
    return p0_f(osr_log2, frac) + p0_f(osr_log2, frac) / 4;
  endfunction

  function automatic int cw_f(int osr_log2, int frac);
    return osr_log2 + frac + 3;
  endfunction

  // Wide enough that a full-scale error plus P0 never wraps.
  function automatic int aw_f(int osr_log2, int frac, int width);
    return (cw_f(osr_log2, frac) > width + 2) ? cw_f(osr_log2, frac) : width + 2;
  endfunction

endpackage

// File: rtl/gardner_timing_nco_if.sv
// Sample/error stream in, strobes and loop status out.
interface gardner_timing_nco_if #(
  parameter int WIDTH    = 16,
  parameter int OSR_LOG2 = 5,
  parameter int FRAC     = 8
);
  logic                         in_valid;
  logic signed [WIDTH-1:0]      i_in, q_in;
  logic                         err_valid;
  logic signed [WIDTH-1:0]      err_n;
  logic                         sym_valid, mid_valid;
  logic signed [WIDTH-1:0]      i_out, q_out;
  logic [FRAC-1:0]              mu;
  logic [OSR_LOG2+FRAC+1:0]     period;
  logic                         period_sat;
  logic                         locked;

  modport master (
    output in_valid, i_in, q_in, err_valid, err_n,
    input  sym_valid, mid_valid, i_out, q_out, mu, period, period_sat, locked
  );
  modport slave (
    input  in_valid, i_in, q_in, err_valid, err_n,
    output sym_valid, mid_valid, i_out, q_out, mu, period, period_sat, locked
  );
endinterface

// File: rtl/gardner_loop_filter.sv
// PI loop filter: clamped integrator and clamped symbol period around P0.
module gardner_loop_filter
  import gardner_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int OSR_LOG2 = 5,
  parameter int FRAC     = 8
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_i,
  input  logic                          upd_i,
  input  logic [3:0]                    kp_shift_i,
  input  logic [3:0]                    ki_shift_i,
  input  logic signed [WIDTH-1:0]       err_i,
  output logic [OSR_LOG2+FRAC+1:0]      period_o,
  output logic                          sat_o
);
  localparam int PW = OSR_LOG2 + FRAC + 2;
  localparam int AW = aw_f(OSR_LOG2, FRAC, WIDTH);
  localparam logic signed [AW-1:0] P0   = AW'(p0_f(OSR_LOG2, FRAC));
  localparam logic signed [AW-1:0] PMIN = AW'(pmin_f(OSR_LOG2, FRAC));
  localparam logic signed [AW-1:0] PMAX = AW'(pmax_f(OSR_LOG2, FRAC));
  localparam logic signed [AW-1:0] ILIM = AW'(p0_f(OSR_LOG2, FRAC) / 4);
  localparam logic signed [AW-1:0] NLIM = -ILIM;

  logic signed [AW-1:0] integ_q, integ_d, e, isum, inew, praw, pclamp;
  logic [PW-1:0]        period_q, period_d;
  logic                 sat_q, sat_d, pclip;

  always_comb begin
    e      = {{(AW-WIDTH){err_i[WIDTH-1]}}, err_i};
    isum   = integ_q + (e >>> ki_shift_i);
    inew   = (isum > ILIM) ? ILIM : (isum < NLIM) ? NLIM : isum;
    praw   = P0 + inew + (e >>> kp_shift_i);
    pclip  = (praw > PMAX) || (praw < PMIN);
    pclamp = (praw > PMAX) ? PMAX : (praw < PMIN) ? PMIN : praw;
    integ_d  = integ_q;
    period_d = period_q;
    sat_d    = sat_q;
    if (clr_i) begin
      integ_d  = '0;
      period_d = PW'(P0);
      sat_d    = 1'b0;
    end else if (upd_i) begin
      integ_d  = inew;
      period_d = PW'(pclamp);
      sat_d    = pclip;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      integ_q  <= '0;
      period_q <= PW'(P0);
      sat_q    <= 1'b0;
    end else begin
      integ_q  <= integ_d;
      period_q <= period_d;
      sat_q    <= sat_d;
    end
  end

  assign period_o = period_q;
  assign sat_o    = sat_q;
endmodule

// File: rtl/gardner_timing_nco.sv
// Symbol-timing NCO: mid/on-time strobes, mu, PI-corrected period and lock flag.
module gardner_timing_nco
  import gardner_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int OSR_LOG2 = 5,
  parameter int FRAC     = 8,
  parameter int LOCK_THR = 512,
  parameter int LOCK_CNT = 16
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic [3:0] kp_shift_i,
  input  logic [3:0] ki_shift_i,
  gardner_timing_nco_if.slave bus
);
  localparam int PW   = OSR_LOG2 + FRAC + 2;
  localparam int CNTW = PW + 1;
  localparam int RW   = $clog2(LOCK_CNT + 1);
  localparam logic [CNTW-1:0] STEP = CNTW'(step_f(FRAC));
  localparam logic [WIDTH:0]  THR  = (WIDTH+1)'(LOCK_THR);

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d, cnt_nxt, per_ext, half;
  logic [PW-1:0]        period;
  logic                 sat, run, clr, upd;
  logic                 sym_q, sym_d, mid_q, mid_d;
  logic [WIDTH-1:0]     iout_q, iout_d, qout_q, qout_d;
  logic [FRAC-1:0]      mu_q, mu_d;
  logic                 lock_q, lock_d, qual;
  logic [RW-1:0]        lrun_q, lrun_d;
  logic [WIDTH:0]       eext, emag;

  assign run = enable_i && (state_q != IDLE);
  assign clr = !run;
  assign upd = run && bus.err_valid;

  gardner_loop_filter #(.WIDTH(WIDTH), .OSR_LOG2(OSR_LOG2), .FRAC(FRAC)) u_lf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .upd_i     (upd),
    .kp_shift_i(kp_shift_i),
    .ki_shift_i(ki_shift_i),
    .err_i     (bus.err_n),
    .period_o  (period),
    .sat_o     (sat)
  );

  assign per_ext = {1'b0, period};
  assign half    = per_ext >> 1;
  assign cnt_nxt = cnt_q + STEP;
  assign eext    = {bus.err_n[WIDTH-1], bus.err_n};
  assign emag    = eext[WIDTH] ? -eext : eext;
  assign qual    = (emag <= THR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = 1'b0;
    mid_d   = 1'b0;
    iout_d  = iout_q;
    qout_d  = qout_q;
    mu_d    = mu_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_i) state_d = FIRST_HALF;
      end
      FIRST_HALF: if (bus.in_valid) begin
        cnt_d = cnt_nxt;
        if (cnt_nxt >= half) begin
          mid_d   = 1'b1;
          iout_d  = bus.i_in;
          qout_d  = bus.q_in;
          state_d = SECOND_HALF;
        end
      end
      SECOND_HALF: if (bus.in_valid) begin
        cnt_d = cnt_nxt;
        if (cnt_nxt >= per_ext) begin
          sym_d   = 1'b1;
          iout_d  = bus.i_in;
          qout_d  = bus.q_in;
          cnt_d   = cnt_nxt - per_ext;
          mu_d    = FRAC'(cnt_nxt - per_ext);
          state_d = FIRST_HALF;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping enable aborts the symbol in progress without a strobe.
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      sym_d   = 1'b0;
      mid_d   = 1'b0;
      iout_d  = iout_q;
      qout_d  = qout_q;
      mu_d    = mu_q;
    end
  end

  // Run counter tracks consecutive symbols of the class opposite to the current lock state.
  always_comb begin
    lock_d = lock_q;
    lrun_d = lrun_q;
    if (!run) begin
      lock_d = 1'b0;
      lrun_d = '0;
    end else if (bus.err_valid) begin
      if (lock_q ^ qual) begin
        if (lrun_q == RW'(LOCK_CNT - 1)) begin
          lock_d = !lock_q;
          lrun_d = '0;
        end else begin
          lrun_d = lrun_q + 1'b1;
        end
      end else begin
        lrun_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sym_q   <= 1'b0;
      mid_q   <= 1'b0;
      iout_q  <= '0;
      qout_q  <= '0;
      mu_q    <= '0;
      lock_q  <= 1'b0;
      lrun_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      mid_q   <= mid_d;
      iout_q  <= iout_d;
      qout_q  <= qout_d;
      mu_q    <= mu_d;
      lock_q  <= lock_d;
      lrun_q  <= lrun_d;
    end
  end

  assign bus.sym_valid  = sym_q;
  assign bus.mid_valid  = mid_q;
  assign bus.i_out      = iout_q;
  assign bus.q_out      = qout_q;
  assign bus.mu         = mu_q;
  assign bus.period     = period;
  assign bus.period_sat = sat;
  assign bus.locked     = lock_q;
endmodule

// File: tb/tb_gardner_timing_nco.sv
// Scoreboard bench: a cycle model predicts strobes, the monitor pops and compares them.
module tb_gardner_timing_nco;
  localparam int P0 = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_i = 1'b0;
  logic [3:0] kp_shift_i = 4'd0;
  logic [3:0] ki_shift_i = 4'd0;

  gardner_timing_nco_if #(.WIDTH(16), .OSR_LOG2(5), .FRAC(8)) bus();

  gardner_timing_nco #(.WIDTH(16), .OSR_LOG2(5), .FRAC(8), .LOCK_THR(512), .LOCK_CNT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_i  (enable_i),
    .kp_shift_i(kp_shift_i),
    .ki_shift_i(ki_shift_i),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {bit is_sym; int cyc; logic [15:0] d; logic [7:0] mu;} exp_t;
  exp_t       exp_q[$];
  int         sym_cycs[$], mid_cycs[$];
  logic [7:0] sym_mus[$];
  int         n_chk = 0, n_fail = 0;

  // reference model state
  int         mcnt = 0, mper = P0, minteg = 0, mrc = 0;
  bit         mrun = 0, msec = 0, msat = 0, mlock = 0, mpend = 0;
  bit         en = 0, rst_drv = 0;
  logic [15:0] sd = 16'd1;
  int         en_edge = 0, rst_edge = 0;

  always @(negedge clk) begin
    exp_t x;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      x = exp_q.pop_front();
      n_chk++; n_fail++;
      $display("FAIL missing_strobe sym=%0b: no strobe at cyc %0d", x.is_sym, x.cyc);
    end
    if (bus.sym_valid || bus.mid_valid) begin
      n_chk++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        n_fail++;
        $display("FAIL unexpected_strobe cyc=%0d sym=%b mid=%b, required none", cyc, bus.sym_valid, bus.mid_valid);
      end else begin
        x = exp_q.pop_front();
        if (bus.sym_valid !== x.is_sym || bus.mid_valid !== !x.is_sym || bus.i_out !== x.d ||
            bus.q_out !== ~x.d || (x.is_sym && bus.mu !== x.mu)) begin
          n_fail++;
          $display("FAIL strobe cyc=%0d sym=%b i=%h q=%h mu=%0d, required sym=%b i=%h q=%h mu=%0d",
                   cyc, bus.sym_valid, bus.i_out, bus.q_out, bus.mu, x.is_sym, x.d, ~x.d, x.mu);
        end
      end
      if (bus.sym_valid) begin sym_cycs.push_back(cyc); sym_mus.push_back(bus.mu); end
      if (bus.mid_valid) mid_cycs.push_back(cyc);
    end
  end

  // One clock: check state from the last edge, drive inputs, advance the model.
  task automatic step(input bit v, input bit ev, input int e);
    int nxt, isum, p, mag;
    exp_t x;
    @(negedge clk);
    n_chk++;
    if (bus.period !== 15'(mper) || bus.period_sat !== msat || bus.locked !== mlock) begin
      n_fail++;
      $display("FAIL state cyc=%0d period=%0d sat=%b locked=%b, required period=%0d sat=%b locked=%b",
               cyc, bus.period, bus.period_sat, bus.locked, mper, msat, mlock);
    end
    rst_n = rst_drv; enable_i = en;
    bus.in_valid = v; bus.i_in = sd; bus.q_in = ~sd;
    bus.err_valid = ev; bus.err_n = e[15:0];
    if (ev) mpend = 0;
    if (!rst_drv || !en) begin
      mrun = 0; msec = 0; mcnt = 0; minteg = 0; mper = P0; msat = 0; mlock = 0; mrc = 0; mpend = 0;
    end else if (!mrun) begin
      mrun = 1;
    end else begin
      if (v) begin
        nxt = mcnt + 256;
        if (!msec) begin
          if (nxt >= mper / 2) begin
            x.is_sym = 0; x.cyc = cyc + 1; x.d = sd; x.mu = 8'd0; exp_q.push_back(x); msec = 1;
          end
        end else if (nxt >= mper) begin
          x.is_sym = 1; x.cyc = cyc + 1; x.d = sd; x.mu = 8'(nxt - mper); exp_q.push_back(x);
          nxt = nxt - mper; msec = 0; mpend = 1;
        end
        mcnt = nxt;
      end
      if (ev) begin
        isum = minteg + (e >>> ki_shift_i);
        if (isum > 2048) isum = 2048; else if (isum < -2048) isum = -2048;
        minteg = isum;
        p = P0 + isum + (e >>> kp_shift_i);
        msat = 0;
        if (p > 10240) begin p = 10240; msat = 1; end
        else if (p < 6144) begin p = 6144; msat = 1; end
        mper = p;
        mag = (e < 0) ? -e : e;
        if (mlock ^ (mag <= 512)) begin
          mrc++;
          if (mrc == 16) begin mlock = !mlock; mrc = 0; end
        end else mrc = 0;
      end
    end
    if (v) sd++;
  endtask

  task automatic restart();
    en = 0; step(0, 0, 0); step(0, 0, 0);
    en = 1; step(0, 0, 0);
    en_edge = cyc + 1;
    sym_cycs.delete(); mid_cycs.delete(); sym_mus.delete();
  endtask

  // Runs until n symbols have had an error sample sent one clock after them.
  task automatic run_syms(input int n, input int e, input bit gap);
    int got = 0, guard = 0;
    bit tog = 0, ev;
    while (got < n && guard < 4000) begin
      ev = mpend;
      if (ev) got++;
      step(gap ? tog : 1'b1, ev, e);
      tog = !tog; guard++;
    end
    n_chk++;
    if (got < n) begin n_fail++; $display("FAIL run_syms_budget got=%0d required=%0d", got, n); end
  endtask

  task automatic test_reset();
    rst_drv = 0; en = 0;
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    n_chk++;
    if (bus.sym_valid !== 1'b0 || bus.mid_valid !== 1'b0 || bus.i_out !== 16'd0 || bus.q_out !== 16'd0 ||
        bus.mu !== 8'd0 || bus.period !== 15'd8192 || bus.period_sat !== 1'b0 || bus.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state sym=%b mid=%b i=%h q=%h mu=%0d period=%0d sat=%b lock=%b, required zeros, period 8192",
               bus.sym_valid, bus.mid_valid, bus.i_out, bus.q_out, bus.mu, bus.period, bus.period_sat, bus.locked);
    end
    rst_drv = 1;
  endtask

  task automatic test_continuous();
    restart();
    run_syms(4, 0, 0); step(1, 0, 0);
    n_chk++;
    if (mid_cycs[0] - en_edge !== 16) begin
      n_fail++; $display("FAIL first_mid_latency got=%0d required=16", mid_cycs[0] - en_edge);
    end
    for (int k = 1; k < 4; k++) begin
      n_chk++;
      if (sym_cycs[k] - sym_cycs[k-1] !== 32 || sym_mus[k] !== 8'd0) begin
        n_fail++; $display("FAIL cont_interval k=%0d got=%0d mu=%0d required=32 mu=0", k, sym_cycs[k] - sym_cycs[k-1], sym_mus[k]);
      end
    end
    n_chk++;
    if (bus.period !== 15'd8192) begin n_fail++; $display("FAIL cont_period got=%0d required=8192", bus.period); end
  endtask

  task automatic test_gapped();
    restart();
    run_syms(4, 0, 1); step(1, 0, 0);
    for (int k = 1; k < 4; k++) begin
      n_chk++;
      if (sym_cycs[k] - sym_cycs[k-1] !== 64 || sym_cycs[k] - mid_cycs[k] !== 32) begin
        n_fail++; $display("FAIL gapped k=%0d interval=%0d mid_to_sym=%0d required 64/32",
                           k, sym_cycs[k] - sym_cycs[k-1], sym_cycs[k] - mid_cycs[k]);
      end
    end
  endtask

  task automatic test_offset();
    int a, b;
    restart(); kp_shift_i = 4'd0; ki_shift_i = 4'd15;
    run_syms(8, 128, 0); step(1, 0, 0);
    n_chk++;
    if (bus.period !== 15'd8320) begin n_fail++; $display("FAIL offset_period got=%0d required=8320", bus.period); end
    for (int k = 4; k < 7; k++) begin
      a = sym_cycs[k] - sym_cycs[k-1]; b = sym_cycs[k+1] - sym_cycs[k];
      n_chk++;
      if (a + b !== 65 || (a !== 32 && a !== 33) || int'(sym_mus[k]) + int'(sym_mus[k+1]) !== 128 ||
          (sym_mus[k] !== 8'd0 && sym_mus[k] !== 8'd128)) begin
        n_fail++; $display("FAIL offset_alt k=%0d intervals=%0d,%0d mu=%0d,%0d required 33/32 alternating, mu 128/0",
                           k, a, b, sym_mus[k], sym_mus[k+1]);
      end
    end
  endtask

  task automatic test_clamp();
    restart(); kp_shift_i = 4'd0; ki_shift_i = 4'd15;
    run_syms(3, 32767, 0); step(1, 0, 0);
    n_chk++;
    if (bus.period !== 15'd10240 || bus.period_sat !== 1'b1 || sym_cycs[2] - sym_cycs[1] !== 40) begin
      n_fail++; $display("FAIL clamp_max period=%0d sat=%b interval=%0d required 10240/1/40",
                         bus.period, bus.period_sat, sym_cycs[2] - sym_cycs[1]);
    end
    run_syms(3, -32768, 0); step(1, 0, 0);
    n_chk++;
    if (bus.period !== 15'd6144 || bus.period_sat !== 1'b1 || sym_cycs[5] - sym_cycs[4] !== 24) begin
      n_fail++; $display("FAIL clamp_min period=%0d sat=%b interval=%0d required 6144/1/24",
                         bus.period, bus.period_sat, sym_cycs[5] - sym_cycs[4]);
    end
  endtask

  task automatic test_lock();
    restart(); kp_shift_i = 4'd0; ki_shift_i = 4'd15;
    run_syms(15, 0, 0); step(1, 0, 0);
    n_chk++;
    if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got=%b required=0", bus.locked); end
    run_syms(1, 0, 0); step(1, 0, 0);
    n_chk++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock_rise got=%b required=1", bus.locked); end
    // drop enable mid-symbol with errors present: both must be ignored
    en = 0; step(1, 1, 32767); step(1, 1, 32767); step(1, 0, 0);
    n_chk++;
    if (bus.locked !== 1'b0 || bus.period !== 15'd8192 || bus.sym_valid !== 1'b0 || bus.mid_valid !== 1'b0) begin
      n_fail++; $display("FAIL enable_drop lock=%b period=%0d sym=%b mid=%b required 0/8192/0/0",
                         bus.locked, bus.period, bus.sym_valid, bus.mid_valid);
    end
    restart();
    run_syms(16, 0, 0); run_syms(15, 1000, 0); step(1, 0, 0);
    n_chk++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock_hold got=%b required=1", bus.locked); end
    run_syms(1, 0, 0); run_syms(15, 1000, 0); step(1, 0, 0);
    n_chk++;
    if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock_rerun got=%b required=1", bus.locked); end
    run_syms(1, 1000, 0); step(1, 0, 0);
    n_chk++;
    if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL lock_fall got=%b required=0", bus.locked); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    restart(); kp_shift_i = 4'd0; ki_shift_i = 4'd15;
    run_syms(1, 0, 0);
    while ((!msec || mcnt < 5000) && guard < 100) begin step(1, 0, 0); guard++; end
    rst_drv = 0; step(1, 0, 0); rst_edge = cyc + 1;
    rst_drv = 1; step(1, 0, 0);
    n_chk++;
    if (bus.sym_valid !== 1'b0 || bus.mid_valid !== 1'b0 || bus.i_out !== 16'd0 || bus.q_out !== 16'd0 ||
        bus.mu !== 8'd0 || bus.period !== 15'd8192 || bus.period_sat !== 1'b0 || bus.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid i=%h q=%h mu=%0d period=%0d sat=%b lock=%b, required zeros, period 8192",
               bus.i_out, bus.q_out, bus.mu, bus.period, bus.period_sat, bus.locked);
    end
    sym_cycs.delete();
    run_syms(4, 0, 0); step(1, 0, 0);
    n_chk++;
    if (sym_cycs[0] - rst_edge !== 33) begin
      n_fail++; $display("FAIL reset_resume_first got=%0d required=33", sym_cycs[0] - rst_edge);
    end
    for (int k = 1; k < 4; k++) begin
      n_chk++;
      if (sym_cycs[k] - sym_cycs[k-1] !== 32) begin
        n_fail++; $display("FAIL reset_resume k=%0d got=%0d required=32", k, sym_cycs[k] - sym_cycs[k-1]);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.i_in = '0; bus.q_in = '0; bus.err_valid = 1'b0; bus.err_n = '0;
    test_reset();
    test_continuous();
    test_gapped();
    test_offset();
    test_clamp();
    test_lock();
    test_reset_mid();
    en = 0; step(0, 0, 0); step(0, 0, 0);
    n_chk++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
